// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared constants for the AVR data-space router.
//   - I/O port addresses decoded below the banked window
//   - bit positions of the keyboard status register
//   - PS/2 prefix bytes
//   - keyboard FIFO entry width
// Optional feature macro: MEMCTRL_KB_EXT_EN (E0 extended-code prefix tracking).
package memctrl_pkg;

    localparam logic [15:0] ADDR_BANK     = 16'h0020;
    localparam logic [15:0] ADDR_KB_DATA  = 16'h0021;
    localparam logic [15:0] ADDR_KB_STAT  = 16'h0022;
    localparam logic [15:0] ADDR_KB_COUNT = 16'h0023;
    localparam logic [15:0] ADDR_CUR_X    = 16'h002C;
    localparam logic [15:0] ADDR_CUR_Y    = 16'h002D;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_REL    = 3;
    localparam int ST_EXT    = 4;

    localparam logic [7:0] PS2_REL_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;

    // Entry layout is {[ext,] release, code[7:0]}.
    localparam int ENT_REL = 8;
    localparam int ENT_EXT = 9;

`ifdef MEMCTRL_KB_EXT_EN
    localparam bit KB_EXT_EN = 1'b1;
`else
    localparam bit KB_EXT_EN = 1'b0;
`endif

    function automatic int kb_entry_w(input bit ext_en);
        return ext_en ? 10 : 9;
    endfunction

    localparam int KB_ENTRY_W = kb_entry_w(KB_EXT_EN);

endpackage

// File: rtl/memctrl_fifo_kb_fifo.sv
// kb_fifo: synchronous FIFO for keyboard entries.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   push, pop, flush    requests; flush has priority over push/pop
//   wdata               entry written on push
//   head                entry at the read pointer (valid when !empty)
//   count, full, empty  occupancy (count ranges 0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
module kb_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 9
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the pop frees this edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/memctrl_fifo.sv
// memctrl_fifo: AVR data-space router, bank/cursor registers and PS/2 FIFO.
// Ports:
//   clock, reset_n                    clock, asynchronous active-low reset
//   address, wren, rden, data_o       AVR data bus (data_o = write data)
//   data_i                            combinational read data to the AVR
//   data_o_sram, data_w_sram          SRAM read data / write enable
//   data_o_ch, data_w_ch              banked channel read data / write enables
//   bank, cursor_x, cursor_y          port registers
//   ps2_data, ps2_hit                 received PS/2 byte and its strobe
//   kb_irq                            FIFO not empty, lagging count by one cycle
// Optional feature macro: MEMCTRL_KB_EXT_EN (E0 sets an ext flag on the next code).
module memctrl_fifo
    import memctrl_pkg::*;
#(
    parameter int          CH_N     = 2,
    parameter logic [15:0] WIN_BASE = 16'hF000,
    parameter int          KB_DEPTH = 8,
    parameter int          KB_AW    = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       address,
    input  logic              wren,
    input  logic              rden,
    input  logic [7:0]        data_o,
    output logic [7:0]        data_i,
    input  logic [7:0]        data_o_sram,
    output logic              data_w_sram,
    input  logic [8*CH_N-1:0] data_o_ch,
    output logic [CH_N-1:0]   data_w_ch,
    output logic [7:0]        bank,
    output logic [7:0]        cursor_x,
    output logic [7:0]        cursor_y,
    input  logic [7:0]        ps2_data,
    input  logic              ps2_hit,
    output logic              kb_irq
);

    logic [KB_ENTRY_W-1:0] kb_head;
    logic [KB_ENTRY_W-1:0] kb_wdata;
    logic [KB_AW:0]        kb_count;
    logic                  kb_full;
    logic                  kb_empty;
    logic                  kb_push;
    logic                  kb_pop;
    logic                  kb_flush;
    logic                  is_rel;
    logic                  is_ext;
    logic                  is_code;
    logic                  ovf_event;
    logic                  rel_pre;
    logic                  overflow;
    logic                  head_ext;
    logic                  head_rel;
    logic [7:0]            status;

    assign is_rel    = ps2_hit && (ps2_data == PS2_REL_PREFIX);
    assign is_code   = ps2_hit && !is_rel && !is_ext;
    assign kb_pop    = rden && (address == ADDR_KB_DATA);
    assign kb_flush  = wren && (address == ADDR_KB_COUNT);
    // A flush in the same cycle swallows the push silently (no overflow).
    assign kb_push   = is_code && !kb_flush;
    assign ovf_event = kb_push && kb_full && !(kb_pop && !kb_empty);
    assign head_rel  = !kb_empty && kb_head[ENT_REL];

`ifdef MEMCTRL_KB_EXT_EN
    logic ext_pre;

    assign is_ext   = ps2_hit && (ps2_data == PS2_EXT_PREFIX);
    assign kb_wdata = {ext_pre, rel_pre, ps2_data};
    assign head_ext = !kb_empty && kb_head[ENT_EXT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     ext_pre <= 1'b0;
        else if (is_ext)  ext_pre <= 1'b1;
        else if (is_code) ext_pre <= 1'b0;
    end
`else
    assign is_ext   = 1'b0;
    assign kb_wdata = {rel_pre, ps2_data};
    assign head_ext = 1'b0;
`endif

    kb_fifo #(
        .DEPTH (KB_DEPTH),
        .AW    (KB_AW),
        .W     (KB_ENTRY_W)
    ) u_kb_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (kb_push),
        .pop     (kb_pop),
        .flush   (kb_flush),
        .wdata   (kb_wdata),
        .head    (kb_head),
        .count   (kb_count),
        .full    (kb_full),
        .empty   (kb_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank     <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            overflow <= 1'b0;
            rel_pre  <= 1'b0;
            kb_irq   <= 1'b0;
        end else begin
            if (wren) begin
                case (address)
                    ADDR_BANK:  bank     <= data_o;
                    ADDR_CUR_X: cursor_x <= data_o;
                    ADDR_CUR_Y: cursor_y <= data_o;
                    default: ;
                endcase
            end
            // A new overflow in the clearing cycle is kept, not lost.
            if (wren && (address == ADDR_KB_STAT) && data_o[ST_OVF]) overflow <= 1'b0;
            if (ovf_event) overflow <= 1'b1;
            if (is_rel)       rel_pre <= 1'b1;
            else if (is_code) rel_pre <= 1'b0;
            kb_irq <= (kb_count != '0);
        end
    end

    always_comb begin
        status            = '0;
        status[ST_NEMPTY] = !kb_empty;
        status[ST_FULL]   = kb_full;
        status[ST_OVF]    = overflow;
        status[ST_REL]    = head_rel;
        status[ST_EXT]    = head_ext;
    end

    always_comb begin
        data_i      = data_o_sram;
        data_w_sram = wren;
        data_w_ch   = '0;
        if (address >= WIN_BASE) begin
            data_w_sram = 1'b0;
            data_i      = 8'hFF;
            // bank values 2k+2 / 2k+3 select channel k
            for (int k = 0; k < CH_N; k++) begin
                if (bank[7:1] == 7'(k + 1)) begin
                    data_w_ch[k] = wren;
                    data_i       = data_o_ch[8*k +: 8];
                end
            end
        end else begin
            case (address)
                ADDR_BANK:     data_i = bank;
                ADDR_KB_DATA:  data_i = kb_empty ? 8'h00 : kb_head[7:0];
                ADDR_KB_STAT:  data_i = status;
                ADDR_KB_COUNT: data_i = 8'(kb_count);
                ADDR_CUR_X:    data_i = cursor_x;
                ADDR_CUR_Y:    data_i = cursor_y;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memctrl_fifo.md
Name: memctrl_fifo

Overview:
- Next-generation AVR data-space router and I/O port block.
- Maps the upper address window onto a parametrised number of banked memory channels.
- Holds bank and cursor registers and buffers PS/2 scancodes in a FIFO, so software no longer polls a toggling latch and loses codes.
- Sits between the AVR core data bus, the SRAM, the banked memories (text and others) and the PS/2 receiver, all in one clock domain.

Parameters:
- CH_N, 2: number of banked window channels; channel k is selected by bank values 2k+2 and 2k+3.
- WIN_BASE, 16'hF000: first address of the banked window.
- KB_DEPTH, 8: keyboard FIFO entries; power of 2, at least 2.
- KB_AW, 3: log2(KB_DEPTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  16  AVR data address.
- wren  in  1  AVR write strobe.
- rden  in  1  AVR read strobe; qualifies FIFO pop.
- data_o  in  8  write data from the AVR.
- data_i  out  8  read data to the AVR (combinational).
- data_o_sram  in  8  SRAM read data.
- data_w_sram  out  1  SRAM write enable.
- data_o_ch  in  8*CH_N  flattened channel read data; channel k is bits [8k+7:8k].
- data_w_ch  out  CH_N  per-channel write enables.
- bank  out  8  bank register.
- cursor_x  out  8  cursor column register.
- cursor_y  out  8  cursor row register.
- ps2_data  in  8  received PS/2 byte.
- ps2_hit  in  1  one-cycle strobe marking ps2_data valid.
- kb_irq  out  1  high while the FIFO is not empty.

Behaviour:
- Reset (asynchronous, active-low):
  - bank, cursor_x, cursor_y = 0.
  - FIFO empty; rd/wr pointers and count = 0.
  - Overflow flag = 0; release-prefix flag = 0.
  - kb_irq = 0.
- Routing (combinational):
  - Default: data_i = data_o_sram, data_w_sram = wren, all data_w_ch = 0.
  - address >= WIN_BASE: data_w_sram = 0.
    - If bank[7:1] is in 1..CH_N, channel k = bank[7:1]-1 gets data_w_ch[k] = wren and data_i = that channel's data.
    - Otherwise data_i = 8'hFF and the write is dropped.
  - address < WIN_BASE, port decode overrides data_i only:
    - 0x20 bank.
    - 0x21 FIFO head code (8'h00 if empty).
    - 0x22 status {3'b0, ext, release, overflow, full, !empty}.
    - 0x23 count, zero-extended.
    - 0x2C cursor_x.
    - 0x2D cursor_y.
  - SRAM write-through still occurs for port addresses, as today.
- Port writes (rising edge, when wren):
  - 0x20 -> bank.
  - 0x2C -> cursor_x.
  - 0x2D -> cursor_y.
  - 0x22 with data_o[2]=1 clears overflow.
  - 0x23 with any data flushes the FIFO (pointers and count = 0).
- FIFO entry: {ext, release, code[7:0]}; ext is constant 0 unless KB_EXT_EN is defined.
- Push (on ps2_hit):
  - ps2_data = 8'hF0: sets the release-prefix flag; nothing pushed.
  - Any other byte: pushes {ext, release-prefix, ps2_data}, then clears the prefix flag(s).
  - If full and no pop in the same cycle: entry dropped, overflow set (sticky); prefix flags still cleared.
- Pop: on a rising edge with rden && address==0x21 && !empty; the head visible on data_i in that cycle is consumed. Pop while empty: no state change.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - When full this is not an overflow.
  - When empty the pop is ignored and the push succeeds.
- Pointers wrap modulo KB_DEPTH; count ranges 0..KB_DEPTH. full = (count==KB_DEPTH).
- Flush and push in the same cycle: flush wins; the push is lost without setting overflow.
- kb_irq = !empty, registered from count, so it updates one cycle after the push or pop edge.
- Reset asserted mid-operation clears everything immediately; a ps2_hit during reset is lost.

Optional Feature:
- Macro: MEMCTRL_KB_EXT_EN.
- Defined:
  - ps2_hit with 8'hE0 sets an ext-prefix flag and pushes nothing.
  - The next pushed code carries ext=1; the sequence E0 F0 xx yields ext=1, release=1.
  - Status bit4 reflects the head's ext bit.
- Undefined:
  - E0 is pushed as an ordinary code; ext is always 0.
  - FIFO entries are 9 bits wide.

Decomposition:
- Package memctrl_pkg holds:
  - Port address constants (0x20, 0x21, 0x22, 0x23, 0x2C, 0x2D).
  - Status bit positions.
  - PS/2 prefix constants (F0, E0).
  - The FIFO entry width function/typedef.
- One sub-module, kb_fifo: a synchronous FIFO with push, pop, flush, count, full and empty, parametrised by depth and entry width.
- Routing, port registers and prefix decoding stay in memctrl_fifo.

Test Plan:
- Reset, then read 0x20/0x22/0x23 -> 8'h00 each; kb_irq = 0; write bank=0x02, read 0xF000 -> data_o_ch[7:0]; wren at 0xF000 -> data_w_ch = 2'b01, data_w_sram = 0.
- bank=0x04 -> channel 1 selected; bank=0x06 with CH_N=2 -> data_i = 8'hFF and no write enables; bank=0x00 at 0xF000 -> 8'hFF.
- Push 0x1C, then F0 then 0x1C -> count 2; first pop reads 0x1C with status release=0; second pop reads 0x1C with release=1; count 0; kb_irq falls one cycle later.
- Push 9 codes with KB_DEPTH=8 -> count 8, full=1, overflow=1, ninth code dropped; write 0x04 to 0x22 -> overflow=0.
- With the FIFO full, push and pop in the same cycle -> count stays 8, overflow stays 0, FIFO order preserved; write 0x23 -> count 0.
- MEMCTRL_KB_EXT_EN defined, push E0 F0 0x75 -> one entry 0x75; status ext=1, release=1; undefined -> two entries, E0 then 0x75 with release=1.
